ecc_operand_feeder: RTL and testbench

ECC_OPERAND_FEEDER -- requirements
Module: ecc_operand_feeder

---
 rtl/ecc_operand_feeder_pkg.sv | 31 +++
 rtl/ecc_operand_feeder_piso.sv | 32 +++
 rtl/ecc_operand_feeder.sv | 163 ++++++++++++++++
 tb/tb_ecc_operand_feeder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_operand_feeder_pkg.sv
// Shared ECC definitions: operand width codes and width helpers used by the
// operand feeder and the core wrapper.
package ecc_operand_feeder_pkg;

  localparam int ECC_MAX_BITS = 128;

  typedef enum logic [1:0] {
    BITS16  = 2'b00,
    BITS32  = 2'b01,
    BITS64  = 2'b10,
    BITS128 = 2'b11
  } ecc_mode_e;

  function automatic int width_from_mode(input logic [1:0] mode);
    case (mode)
      BITS16:  return 16;
      BITS32:  return 32;
      BITS64:  return 64;
      default: return 128;
    endcase
  endfunction

  // Index of the first serialized bit, clamped to the physical lane width.
  function automatic int last_idx(input logic [1:0] mode, input int max_bits);
    int w;
    w = width_from_mode(mode);
    if (w > max_bits) w = max_bits;
    return w - 1;
  endfunction

endpackage

// File: rtl/ecc_operand_feeder_piso.sv
// One serializer lane: parallel load, emits bit W-1 of the current contents,
// shifts left so the next lower bit moves into the emitted position.
module ecc_piso_lane
  import ecc_operand_feeder_pkg::*;
#(
  parameter int MAX_BITS = ECC_MAX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clr,
  input  logic                shift,
  input  logic [1:0]          mode,
  input  logic [MAX_BITS-1:0] din,
  output logic                msb
);

  localparam int SW = $clog2(MAX_BITS);

  logic [MAX_BITS-1:0] sr;
  logic [SW-1:0]       sel;

  assign sel = SW'(last_idx(mode, MAX_BITS));
  assign msb = sr[sel];

  always_ff @(posedge clk) begin
    if (rst || clr)  sr <= '0;
    else if (load)   sr <= din;
    else if (shift)  sr <= sr << 1;
  end

endmodule

// File: rtl/ecc_operand_feeder.sv
// Serializes one mP job (mode header + five operands) followed by an nP point
// frame, all MSB-first, with registered outputs that idle low between frames.
module ecc_operand_feeder
  import ecc_operand_feeder_pkg::*;
#(
  parameter int MAX_BITS = ECC_MAX_BITS,
  parameter int NP_GAP   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [MAX_BITS-1:0] cmd_a,
  input  logic [MAX_BITS-1:0] cmd_prime,
  input  logic [MAX_BITS-1:0] cmd_Px,
  input  logic [MAX_BITS-1:0] cmd_Py,
  input  logic [MAX_BITS-1:0] cmd_m,
  input  logic                np_valid,
  output logic                np_ready,
  input  logic [MAX_BITS-1:0] np_x,
  input  logic [MAX_BITS-1:0] np_y,
  output logic                o_m_P_valid,
  output logic                o_mode,
  output logic                o_a,
  output logic                o_prime,
  output logic                o_Px,
  output logic                o_Py,
  output logic                o_m,
  output logic                o_nP_valid,
  output logic                o_nPx,
  output logic                o_nPy
);

  localparam int CW    = $clog2(MAX_BITS);
  localparam int LANES = 7;
  localparam int L_A = 0, L_PRIME = 1, L_PX = 2, L_PY = 3, L_M = 4, L_NPX = 5, L_NPY = 6;
  localparam logic [CW-1:0] GAP_LAST = CW'(NP_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, MODE, MP_DATA, GAP, WAIT_NP, NP_HDR, NP_DATA
  } state_e;

  state_e        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] w_last;
  logic [1:0]    mode_q;
  logic          np_full;
  logic          cmd_acc, np_acc, np_hit;
  logic          mp_shift, np_shift, np_clr;

  logic [LANES-1:0][MAX_BITS-1:0] lane_din;
  logic [LANES-1:0]               lane_load, lane_shift, lane_clr, lane_bit;

  assign cmd_acc  = cmd_valid & cmd_ready;
  assign np_ready = (state != IDLE) && !np_full;
  assign np_acc   = np_valid & np_ready;
  assign np_hit   = np_full | np_acc;
  assign w_last   = CW'(last_idx(mode_q, MAX_BITS));

  assign mp_shift = (state == MP_DATA);
  assign np_shift = (state == NP_DATA);
  assign np_clr   = np_shift && (cnt == '0);

  assign lane_din[L_A]     = cmd_a;
  assign lane_din[L_PRIME] = cmd_prime;
  assign lane_din[L_PX]    = cmd_Px;
  assign lane_din[L_PY]    = cmd_Py;
  assign lane_din[L_M]     = cmd_m;
  assign lane_din[L_NPX]   = np_x;
  assign lane_din[L_NPY]   = np_y;

  assign lane_load  = {{2{np_acc}},   {5{cmd_acc}}};
  assign lane_shift = {{2{np_shift}}, {5{mp_shift}}};
  assign lane_clr   = {{2{np_clr}},   5'b0};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ecc_piso_lane #(.MAX_BITS(MAX_BITS)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (lane_load[i]),
      .clr   (lane_clr[i]),
      .shift (lane_shift[i]),
      .mode  (mode_q),
      .din   (lane_din[i]),
      .msb   (lane_bit[i])
    );
  end

  // The counter saturates at 0 on every terminal phase instead of wrapping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE:    if (cmd_acc) state_nxt = HDR;
      HDR: begin
        state_nxt = MODE;
        cnt_nxt   = CW'(1);
      end
      MODE:
        if (cnt == '0) begin
          state_nxt = MP_DATA;
          cnt_nxt   = w_last;
        end else cnt_nxt = cnt - CW'(1);
      MP_DATA:
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LAST;
        end else cnt_nxt = cnt - CW'(1);
      GAP:
        if (cnt == '0) state_nxt = np_hit ? NP_HDR : WAIT_NP;
        else           cnt_nxt   = cnt - CW'(1);
      WAIT_NP: if (np_hit) state_nxt = NP_HDR;
      NP_HDR: begin
        state_nxt = NP_DATA;
        cnt_nxt   = w_last;
      end
      NP_DATA:
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mode_q      <= '0;
      np_full     <= 1'b0;
      cmd_ready   <= 1'b1;
      o_m_P_valid <= 1'b0;
      o_mode      <= 1'b0;
      o_a         <= 1'b0;
      o_prime     <= 1'b0;
      o_Px        <= 1'b0;
      o_Py        <= 1'b0;
      o_m         <= 1'b0;
      o_nP_valid  <= 1'b0;
      o_nPx       <= 1'b0;
      o_nPy       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Ready rises one cycle after the job ends, so the IDLE entry cycle is quiet.
      cmd_ready <= (state == IDLE) && !cmd_acc;
      if (cmd_acc) mode_q <= cmd_mode;
      if (np_acc)      np_full <= 1'b1;
      else if (np_clr) np_full <= 1'b0;
      o_m_P_valid <= (state == HDR);
      o_mode      <= (state == MODE) && mode_q[cnt[0]];
      o_a         <= mp_shift && lane_bit[L_A];
      o_prime     <= mp_shift && lane_bit[L_PRIME];
      o_Px        <= mp_shift && lane_bit[L_PX];
      o_Py        <= mp_shift && lane_bit[L_PY];
      o_m         <= mp_shift && lane_bit[L_M];
      o_nP_valid  <= (state == NP_HDR);
      o_nPx       <= np_shift && lane_bit[L_NPX];
      o_nPy       <= np_shift && lane_bit[L_NPY];
    end
  end

endmodule

// File: tb/tb_ecc_operand_feeder.sv
// Directed bench for ecc_operand_feeder: frame timing, MSB-first streams,
// nP buffering/wait, upper-bit masking, mid-frame reset and back-to-back jobs.
module tb_ecc_operand_feeder;

  logic         clk = 1'b0;
  logic         rst, cmd_valid, np_valid;
  logic         cmd_ready, np_ready;
  logic [1:0]   cmd_mode;
  logic [127:0] cmd_a, cmd_prime, cmd_Px, cmd_Py, cmd_m, np_x, np_y;
  logic         o_m_P_valid, o_mode, o_a, o_prime, o_Px, o_Py, o_m;
  logic         o_nP_valid, o_nPx, o_nPy;
  logic [9:0]   outs;

  int n_err = 0, n_checks = 0;
  logic [127:0] s_a, s_prime, s_px, s_py, s_m, s_npx, s_npy;
  logic [9:0]   acc;
  logic         bad;

  always #5 clk = ~clk;

  assign outs = {o_m_P_valid, o_mode, o_a, o_prime, o_Px, o_Py, o_m, o_nP_valid, o_nPx, o_nPy};

  ecc_operand_feeder #(.MAX_BITS(128), .NP_GAP(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_a(cmd_a), .cmd_prime(cmd_prime), .cmd_Px(cmd_Px), .cmd_Py(cmd_Py), .cmd_m(cmd_m),
    .np_valid(np_valid), .np_ready(np_ready), .np_x(np_x), .np_y(np_y),
    .o_m_P_valid(o_m_P_valid), .o_mode(o_mode), .o_a(o_a), .o_prime(o_prime),
    .o_Px(o_Px), .o_Py(o_Py), .o_m(o_m),
    .o_nP_valid(o_nP_valid), .o_nPx(o_nPx), .o_nPy(o_nPy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_s();
    s_a = '0; s_prime = '0; s_px = '0; s_py = '0; s_m = '0; s_npx = '0; s_npy = '0;
  endtask

  task automatic sample_mp();
    s_a     = {s_a[126:0], o_a};
    s_prime = {s_prime[126:0], o_prime};
    s_px    = {s_px[126:0], o_Px};
    s_py    = {s_py[126:0], o_Py};
    s_m     = {s_m[126:0], o_m};
  endtask

  task automatic grab(input int n);
    repeat (n) begin tick(); sample_mp(); end
  endtask

  task automatic grab_np(input int n);
    repeat (n) begin
      tick();
      s_npx = {s_npx[126:0], o_nPx};
      s_npy = {s_npy[126:0], o_nPy};
    end
  endtask

  // Returns right after the acceptance edge (cycle T).
  task automatic do_accept(input logic keep);
    int k = 0;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 1000) begin tick(); k++; end
    chk("accept_wait", cmd_ready, 1'b1);
    tick();
    if (!keep) cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; np_valid = 1'b0; cmd_mode = 2'b00;
    cmd_a = '0; cmd_prime = '0; cmd_Px = '0; cmd_Py = '0; cmd_m = '0; np_x = '0; np_y = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_np_ready", np_ready, 1'b0);
    chk("rst_outs", outs, 10'b0);

    // Job 1: 16-bit, nP offered during HDR.
    cmd_mode = 2'b00; cmd_a = 128'h0001; cmd_prime = 128'hFFF1;
    cmd_Px = 128'h8000; cmd_Py = 128'h5A3C; cmd_m = 128'hA5A5;
    do_accept(1'b0);
    clr_s();
    chk("j1_ready_low", cmd_ready, 1'b0);
    chk("j1_np_ready_hdr", np_ready, 1'b1);
    np_valid = 1'b1; np_x = 128'hBEEF; np_y = 128'h0F0F;
    tick();
    np_valid = 1'b0;
    chk("j1_mpv", o_m_P_valid, 1'b1);
    tick();
    chk("j1_mode1", o_mode, 1'b0);
    chk("j1_mpv_pulse", o_m_P_valid, 1'b0);
    tick();
    chk("j1_mode0", o_mode, 1'b0);
    grab(16);
    chk("j1_m", s_m, 128'hA5A5);
    chk("j1_px", s_px, 128'h8000);
    chk("j1_a", s_a, 128'h0001);
    chk("j1_prime", s_prime, 128'hFFF1);
    chk("j1_py", s_py, 128'h5A3C);
    tick();
    chk("j1_gap_outs", outs, 10'b0);
    tick();
    chk("j1_npv", o_nP_valid, 1'b1);
    grab_np(16);
    chk("j1_npx", s_npx, 128'hBEEF);
    chk("j1_npy", s_npy, 128'h0F0F);
    chk("j1_last_ready", cmd_ready, 1'b0);
    tick();
    chk("j1_done_ready", cmd_ready, 1'b1);
    chk("j1_done_outs", outs, 10'b0);

    // Job 2: 128-bit, cmd_valid held, nP offered in MP_DATA, fields change after accept.
    cmd_mode = 2'b11; cmd_a = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    cmd_prime = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF61;
    cmd_Px = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    cmd_Py = 128'h1; cmd_m = 128'hA5A5_5A5A_0000_FFFF_1234_5678_9ABC_DEF0;
    do_accept(1'b1);
    clr_s();
    tick();
    chk("j2_mpv", o_m_P_valid, 1'b1);
    tick();
    chk("j2_mode1", o_mode, 1'b1);
    tick();
    chk("j2_mode0", o_mode, 1'b1);
    cmd_mode = 2'b01; cmd_a = 128'h1; cmd_prime = 128'hFFFF_FFFB;
    cmd_Px = 128'h0; cmd_Py = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_C0FF_EE11;
    cmd_m = 128'h8000_0001;
    np_valid = 1'b1; np_x = 128'h1; np_y = 128'h8000_0000_0000_0000_0000_0000_0000_0003;
    chk("j2_np_ready_data", np_ready, 1'b1);
    tick();
    np_valid = 1'b0;
    sample_mp();
    grab(127);
    chk("j2_a", s_a, 128'h8000_0000_0000_0000_0000_0000_0000_0001);
    chk("j2_prime", s_prime, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF61);
    chk("j2_px", s_px, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("j2_m", s_m, 128'hA5A5_5A5A_0000_FFFF_1234_5678_9ABC_DEF0);
    chk("j2_no_reaccept", cmd_ready, 1'b0);
    tick();
    chk("j2_gap_outs", outs, 10'b0);
    tick();
    chk("j2_npv_t133", o_nP_valid, 1'b1);
    grab_np(128);
    chk("j2_npx", s_npx, 128'h1);
    chk("j2_npy", s_npy, 128'h8000_0000_0000_0000_0000_0000_0000_0003);
    chk("j2_t261_ready", cmd_ready, 1'b0);
    tick();
    chk("j2_t262_ready", cmd_ready, 1'b1);
    tick();
    // Job 3 accepted on this edge from the still-high cmd_valid.
    cmd_valid = 1'b0;
    chk("j3_accepted", cmd_ready, 1'b0);
    clr_s();
    tick();
    chk("j3_mpv", o_m_P_valid, 1'b1);
    tick();
    chk("j3_mode1", o_mode, 1'b0);
    tick();
    chk("j3_mode0", o_mode, 1'b1);
    grab(32);
    chk("j3_py", s_py, 128'hC0FF_EE11);
    chk("j3_prime", s_prime, 128'hFFFF_FFFB);
    chk("j3_m", s_m, 128'h8000_0001);
    acc = '0; bad = 1'b0;
    repeat (50) begin
      tick();
      acc |= outs;
      if (!np_ready || cmd_ready) bad = 1'b1;
    end
    chk("j3_wait_outs", acc, 10'b0);
    chk("j3_wait_handshake", bad, 1'b0);
    np_valid = 1'b1;
    np_x = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_8000_0001;
    np_y = 128'hFFFF_0000_FFFF_0000_FFFF_0000_1234_5678;
    tick();
    np_valid = 1'b0;
    chk("j3_npv_at_accept", o_nP_valid, 1'b0);
    chk("j3_np_full", np_ready, 1'b0);
    tick();
    chk("j3_npv", o_nP_valid, 1'b1);
    grab_np(32);
    chk("j3_npx", s_npx, 128'h8000_0001);
    chk("j3_npy", s_npy, 128'h1234_5678);
    tick();
    chk("j3_done_ready", cmd_ready, 1'b1);

    // Job 4: 16-bit with set upper bits only.
    cmd_mode = 2'b00; cmd_m = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000;
    cmd_a = 128'h1_0000; cmd_prime = 128'h3_8001; cmd_Px = 128'h0; cmd_Py = 128'h0;
    do_accept(1'b0);
    clr_s();
    np_valid = 1'b1; np_x = 128'h00FF; np_y = 128'h0;
    tick();
    np_valid = 1'b0;
    tick(); tick();
    grab(16);
    chk("j4_m_masked", s_m, 128'h0);
    chk("j4_a_masked", s_a, 128'h0);
    chk("j4_prime_masked", s_prime, 128'h8001);
    repeat (19) tick();
    chk("j4_done_ready", cmd_ready, 1'b1);

    // Job 5: 64-bit interrupted by reset together with an nP handshake.
    cmd_mode = 2'b10; cmd_Px = 128'hFFFF_FFFF_FFFF_FFFF; cmd_m = 128'hFFFF_FFFF_FFFF_FFFF;
    do_accept(1'b0);
    repeat (9) tick();
    rst = 1'b1; np_valid = 1'b1; np_x = '1; np_y = '1;
    chk("j5_np_live", np_ready, 1'b1);
    tick();
    rst = 1'b0; np_valid = 1'b0;
    tick();
    chk("j5_rst_outs", outs, 10'b0);
    chk("j5_rst_cmd_ready", cmd_ready, 1'b1);
    chk("j5_rst_np_ready", np_ready, 1'b0);
    cmd_mode = 2'b00; cmd_Px = 128'h1357; cmd_m = 128'h0;
    do_accept(1'b0);
    clr_s();
    chk("j6_np_buffer_empty", np_ready, 1'b1);
    np_valid = 1'b1; np_x = 128'h8001; np_y = 128'h7FFE;
    tick();
    np_valid = 1'b0;
    chk("j6_mpv", o_m_P_valid, 1'b1);
    tick(); tick();
    grab(16);
    chk("j6_px", s_px, 128'h1357);
    tick(); tick();
    chk("j6_npv", o_nP_valid, 1'b1);
    grab_np(16);
    chk("j6_npx", s_npx, 128'h8001);
    chk("j6_npy", s_npy, 128'h7FFE);
    tick();
    chk("j6_done_ready", cmd_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
